// File: rtl/sort_arbiter.sv
// sort_arbiter: round-robin arbiter sharing one sorting engine between
// two packet sources, with length enforcement and ownership tagging.
// Ports: clk_i, arst_n_i; req_data_i/req_sop_i/req_eop_i/req_val_i in,
// req_rdy_o out (per requester); srt_data_o/srt_sop_o/srt_eop_o/
// srt_val_o to the engine, srt_busy_i from it; owner_o, gnt_o, err_o.
module sort_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic [1:0][DWIDTH-1:0] req_data_i,
  input  logic [1:0]             req_sop_i,
  input  logic [1:0]             req_eop_i,
  input  logic [1:0]             req_val_i,
  output logic [1:0]             req_rdy_o,
  output logic [DWIDTH-1:0]      srt_data_o,
  output logic                   srt_sop_o,
  output logic                   srt_eop_o,
  output logic                   srt_val_o,
  input  logic                   srt_busy_i,
  output logic                   owner_o,
  output logic                   gnt_o,
  output logic                   err_o
);
  typedef enum logic [2:0] {
    IDLE, FWD, DISCARD, WAIT_HI, WAIT_LO
  } state_t;

  state_t            r_state, w_state;
  logic              r_last, w_last;
  logic              r_owner, w_owner;
  logic [AWIDTH-1:0] r_cnt, w_cnt;
  logic [1:0]        r_wcnt, w_wcnt;
  logic              r_err, w_err;
  logic              r_val, w_val;
  logic              r_sop, w_sop;
  logic              r_eop, w_eop;
  logic [DWIDTH-1:0] r_data, w_data;
  logic [1:0]        w_rdy;
  logic [1:0]        w_cand;
  logic              w_beat;

  assign w_cand = req_val_i & req_sop_i;
  assign w_beat = req_val_i[r_owner];

  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_owner = r_owner;
    w_cnt   = r_cnt;
    w_wcnt  = r_wcnt;
    w_err   = 1'b0;
    w_val   = 1'b0;
    w_sop   = 1'b0;
    w_eop   = 1'b0;
    w_data  = r_data;
    w_rdy   = '0;
    unique case (r_state)
      IDLE: begin
        // non-sop beats here are strays: swallow and flag them
        w_rdy = req_val_i & ~req_sop_i;
        w_err = |w_rdy;
        if (!srt_busy_i && |w_cand) begin
          w_state = FWD;
          w_cnt   = '0;
          w_owner = (&w_cand) ? ~r_last : w_cand[1];
        end
      end
      FWD: begin
        w_rdy[r_owner] = 1'b1;
        if (w_beat) begin
          w_val  = 1'b1;
          w_sop  = (r_cnt == '0);
          w_data = req_data_i[r_owner];
          w_cnt  = r_cnt + 1'b1;
          if (req_eop_i[r_owner]) begin
            w_eop   = 1'b1;
            w_state = WAIT_HI;
            w_wcnt  = '0;
          end else if (&r_cnt) begin
            // engine full: close the packet, drop the rest
            w_eop   = 1'b1;
            w_err   = 1'b1;
            w_state = DISCARD;
          end
        end
      end
      DISCARD: begin
        w_rdy[r_owner] = 1'b1;
        if (w_beat && req_eop_i[r_owner]) begin
          w_state = WAIT_HI;
          w_wcnt  = '0;
        end
      end
      WAIT_HI: begin
        if (srt_busy_i) begin
          w_state = WAIT_LO;
        end else if (r_wcnt == 2'd2) begin
          w_state = IDLE;
          w_last  = r_owner;
        end else begin
          w_wcnt = r_wcnt + 2'd1;
        end
      end
      WAIT_LO: begin
        if (!srt_busy_i) begin
          w_state = IDLE;
          w_last  = r_owner;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_err   <= 1'b0;
      r_val   <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_owner <= w_owner;
      r_cnt   <= w_cnt;
      r_wcnt  <= w_wcnt;
      r_err   <= w_err;
      r_val   <= w_val;
      r_sop   <= w_sop;
      r_eop   <= w_eop;
      r_data  <= w_data;
    end
  end

  // reset holds rdy low even while a source keeps val asserted
  assign req_rdy_o  = w_rdy & {2{arst_n_i}};
  assign srt_data_o = r_data;
  assign srt_val_o  = r_val;
  assign srt_sop_o  = r_sop;
  assign srt_eop_o  = r_eop;
  assign owner_o    = r_owner;
  assign gnt_o      = (r_state != IDLE);
  assign err_o      = r_err;
endmodule

// File: tb/tb_sort_arbiter.sv
// tb_sort_arbiter: randomized self-checking bench for sort_arbiter
// with a packet-level reference model and a behavioural engine model.
module tb_sort_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int MAXLEN = 1 << AW;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  logic [1:0][DW-1:0] req_data = '0;
  logic [1:0] req_sop = '0;
  logic [1:0] req_eop = '0;
  logic [1:0] req_val = '0;
  logic [1:0] req_rdy;
  logic [DW-1:0] srt_data;
  logic srt_sop, srt_eop, srt_val;
  logic busy = 1'b0;
  logic owner, gnt, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_cnt = 0;
  bit busy_en = 1'b0;
  int busy_dly = 2;
  int busy_len = 10;
  int busy_cd = 0;
  int busy_left = 0;
  bit rr_done = 1'b0;
  int rr_bad = 0;
  logic gnt_h [0:8191];
  logic [DW-1:0] pkt [2][16];

  typedef struct {
    logic [DW-1:0] d;
    logic sop;
    logic eop;
    logic own;
    logic err;
    int cyc;
  } beat_t;
  beat_t obs_q[$];
  beat_t exp_q[$];

  sort_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .req_data_i(req_data), .req_sop_i(req_sop),
    .req_eop_i(req_eop), .req_val_i(req_val),
    .req_rdy_o(req_rdy),
    .srt_data_o(srt_data), .srt_sop_o(srt_sop),
    .srt_eop_o(srt_eop), .srt_val_o(srt_val),
    .srt_busy_i(busy), .owner_o(owner),
    .gnt_o(gnt), .err_o(err)
  );

  always #5 clk = ~clk;

  // output monitor
  initial forever begin
    beat_t b;
    @(posedge clk);
    cyc++;
    #1;
    gnt_h[cyc % 8192] = gnt;
    if (srt_val) begin
      b.d = srt_data; b.sop = srt_sop; b.eop = srt_eop;
      b.own = owner; b.err = err; b.cyc = cyc;
      obs_q.push_back(b);
    end
    if (err) err_cnt++;
  end

  // engine model: busy rises busy_dly cycles after eop, lasts busy_len
  initial forever begin
    @(negedge clk);
    if (busy_cd > 0) begin
      busy_cd--;
      if (busy_cd == 0) begin
        busy = 1'b1;
        busy_left = busy_len;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy = 1'b0;
    end
    if (busy_en && srt_val && srt_eop) busy_cd = busy_dly;
  end

  function automatic logic [DW+3:0] pk(input beat_t b);
    return {b.d, b.sop, b.eop, b.own, b.err};
  endfunction

  // reference: what the engine must see for one packet
  task automatic model_pkt(input int k, input int n);
    for (int i = 0; i < n && i < MAXLEN; i++) begin
      beat_t b;
      b.d = pkt[k][i];
      b.sop = (i == 0);
      b.eop = (i == n - 1) || (i == MAXLEN - 1);
      b.own = k[0];
      b.err = (i == MAXLEN - 1) && (n > MAXLEN);
      b.cyc = 0;
      exp_q.push_back(b);
    end
  endtask

  task automatic fill(input int k, input int n);
    for (int i = 0; i < n; i++) pkt[k][i] = 8'($urandom);
  endtask

  task automatic send_pkt(input int k, input int n);
    int i = 0;
    int g = 0;
    logic acc;
    while (i < n && g < 300) begin
      req_val[k] = 1'b1;
      req_sop[k] = (i == 0);
      req_eop[k] = (i == n - 1);
      req_data[k] = pkt[k][i];
      #1;
      acc = req_rdy[k];
      @(negedge clk);
      if (acc) i++;
      g++;
    end
    req_val[k] = 1'b0;
    req_sop[k] = 1'b0;
    req_eop[k] = 1'b0;
    if (i < n) begin
      checks++; errors++;
      $display("FAIL send_req%0d: sent %0d words, required %0d", k, i, n);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((gnt || busy || busy_cd != 0 || busy_left != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      checks++; errors++;
      $display("FAIL wait_idle: gnt=%b busy=%b, required both 0", gnt, busy);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    arst_n = 1'b0;
    req_val = '0; req_sop = '0; req_eop = '0;
    busy = 1'b0; busy_cd = 0; busy_left = 0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 arst_n = 1'b0;
    #2;
    checks++;
    if (req_rdy !== 2'b00) begin
      errors++; $display("FAIL reset_rdy: got %b, required 00", req_rdy);
    end
    checks++;
    if (srt_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h, required 00", srt_data);
    end
    checks++;
    if ({srt_val, srt_sop, srt_eop} !== 3'b000) begin
      errors++;
      $display("FAIL reset_srt: got %b, required 000", {srt_val, srt_sop, srt_eop});
    end
    checks++;
    if ({owner, gnt, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got %b, required 000", {owner, gnt, err});
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_rdy, gnt, srt_val} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: got %b, required 0000", {req_rdy, gnt, srt_val});
    end
  endtask

  task automatic test_single_pkt();
    int t0;
    bit prevb = 1'b0;
    bit done = 1'b0;
    int bad = 0;
    busy_en = 1'b1; busy_dly = 2; busy_len = 10;
    obs_q.delete(); exp_q.delete();
    pkt[0][0] = 8'd3; pkt[0][1] = 8'd1; pkt[0][2] = 8'd4;
    pkt[0][3] = 8'd1; pkt[0][4] = 8'd5;
    model_pkt(0, 5);
    t0 = cyc;
    send_pkt(0, 5);
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #2;
      if (gnt) begin
        if (owner !== 1'b0) bad++;
        prevb = busy;
      end else begin
        done = 1'b1;
        checks++;
        if (busy !== 1'b0 || prevb !== 1'b1) begin
          errors++;
          $display("FAIL single_gnt_drop: busy=%b prev=%b, required 0/1", busy, prevb);
        end
      end
    end
    checks++;
    if (!done || bad != 0) begin
      errors++;
      $display("FAIL single_hold: done=%b bad_owner=%0d, required 1/0", done, bad);
    end
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (pk(obs_q[i]) !== pk(exp_q[i]) || obs_q[i].cyc != t0 + 2 + i) begin
          errors++;
          $display("FAIL single_beat%0d: got %h@%0d, required %h@%0d",
                   i, pk(obs_q[i]), obs_q[i].cyc, pk(exp_q[i]), t0 + 2 + i);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int last_m = 1;
    apply_reset();
    busy_en = 1'b1; busy_dly = 1; busy_len = 3;
    obs_q.delete(); exp_q.delete();
    rr_bad = 0;
    for (int r = 0; r < 2; r++) begin
      int n0, n1, w;
      n0 = $urandom_range(1, 6);
      n1 = $urandom_range(1, 6);
      fill(0, n0);
      fill(1, n1);
      w = 1 - last_m;
      model_pkt(w, (w == 0) ? n0 : n1);
      model_pkt(1 - w, (w == 0) ? n1 : n0);
      last_m = 1 - w;
      rr_done = 1'b0;
      fork
        begin
          fork
            send_pkt(0, n0);
            send_pkt(1, n1);
          join
          rr_done = 1'b1;
        end
        begin
          while (!rr_done) begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 2; k++)
              if (req_rdy[k] && !(gnt && owner == k[0])) rr_bad++;
          end
        end
      join
    end
    wait_idle();
    checks++;
    if (rr_bad != 0) begin
      errors++;
      $display("FAIL rr_loser_rdy: got %0d bad cycles, required 0", rr_bad);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rr_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (pk(obs_q[i]) !== pk(exp_q[i])) begin
          errors++;
          $display("FAIL rr_beat%0d: got %h, required %h", i, pk(obs_q[i]), pk(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_truncate();
    int e0, ca;
    busy_en = 1'b0;
    obs_q.delete(); exp_q.delete();
    e0 = err_cnt;
    fill(1, 11);
    model_pkt(1, 11);
    send_pkt(1, 11);
    ca = cyc;
    wait_idle();
    checks++;
    if (gnt_h[(ca + 2) % 8192] !== 1'b1 || gnt_h[(ca + 3) % 8192] !== 1'b0) begin
      errors++;
      $display("FAIL trunc_wait: gnt=%b%b, required 10",
               gnt_h[(ca + 2) % 8192], gnt_h[(ca + 3) % 8192]);
    end
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL trunc_err: got %0d pulses, required 1", err_cnt - e0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL trunc_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (pk(obs_q[i]) !== pk(exp_q[i])) begin
          errors++;
          $display("FAIL trunc_beat%0d: got %h, required %h", i, pk(obs_q[i]), pk(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_stray();
    for (int k = 0; k < 2; k++) begin
      int e0;
      logic r;
      wait_idle();
      obs_q.delete();
      e0 = err_cnt;
      req_val[k] = 1'b1;
      req_sop[k] = 1'b0;
      req_data[k] = 8'($urandom);
      #1;
      r = req_rdy[k];
      checks++;
      if (r !== 1'b1) begin
        errors++; $display("FAIL stray_rdy%0d: got %b, required 1", k, r);
      end
      @(negedge clk);
      req_val[k] = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (err_cnt - e0 != 1 || obs_q.size() != 0) begin
        errors++;
        $display("FAIL stray_err%0d: got %0d pulses %0d beats, required 1 and 0",
                 k, err_cnt - e0, obs_q.size());
      end
    end
  endtask

  task automatic test_no_busy();
    busy_en = 1'b0;
    obs_q.delete(); exp_q.delete();
    fill(0, 2);
    fill(1, 3);
    model_pkt(0, 2);
    model_pkt(1, 3);
    fork
      send_pkt(0, 2);
      begin
        @(negedge clk);
        send_pkt(1, 3);
      end
    join
    wait_idle();
    checks++;
    if (obs_q.size() != 5) begin
      errors++; $display("FAIL nobusy_len: got %0d beats, required 5", obs_q.size());
    end else begin
      checks++;
      if (obs_q[2].cyc != obs_q[1].cyc + 5 ||
          gnt_h[(obs_q[1].cyc + 3) % 8192] !== 1'b0) begin
        errors++;
        $display("FAIL nobusy_timing: got gap %0d, required 5",
                 obs_q[2].cyc - obs_q[1].cyc);
      end
      foreach (exp_q[i]) begin
        checks++;
        if (pk(obs_q[i]) !== pk(exp_q[i])) begin
          errors++;
          $display("FAIL nobusy_beat%0d: got %h, required %h", i, pk(obs_q[i]), pk(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_random();
    int e0;
    int nerr = 0;
    wait_idle();
    obs_q.delete(); exp_q.delete();
    e0 = err_cnt;
    for (int p = 0; p < 10; p++) begin
      int k, n;
      k = $urandom_range(0, 1);
      n = $urandom_range(1, 12);
      busy_en = 1'($urandom_range(0, 1));
      busy_dly = $urandom_range(1, 3);
      busy_len = $urandom_range(1, 5);
      fill(k, n);
      model_pkt(k, n);
      nerr += (n > MAXLEN) ? 1 : 0;
      send_pkt(k, n);
    end
    wait_idle();
    checks++;
    if (err_cnt - e0 != nerr) begin
      errors++;
      $display("FAIL rand_err: got %0d pulses, required %0d", err_cnt - e0, nerr);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (pk(obs_q[i]) !== pk(exp_q[i])) begin
          errors++;
          $display("FAIL rand_beat%0d: got %h, required %h", i, pk(obs_q[i]), pk(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    int g = 0;
    int neop = 0;
    logic acc;
    busy_en = 1'b1; busy_dly = 1; busy_len = 2;
    wait_idle();
    obs_q.delete(); exp_q.delete();
    fill(1, 6);
    while (i < 3 && g < 50) begin
      req_val[1] = 1'b1;
      req_sop[1] = (i == 0);
      req_eop[1] = 1'b0;
      req_data[1] = pkt[1][i];
      #1;
      acc = req_rdy[1];
      @(negedge clk);
      if (acc) i++;
      g++;
    end
    req_sop[1] = 1'b0;
    req_data[1] = pkt[1][3];
    arst_n = 1'b0;
    #1;
    checks++;
    if ({req_rdy, srt_data, srt_val, srt_sop, srt_eop, owner, gnt, err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_out: got %h, required 0",
               {req_rdy, srt_data, srt_val, srt_sop, srt_eop, owner, gnt, err});
    end
    foreach (obs_q[j]) if (obs_q[j].eop) neop++;
    checks++;
    if (obs_q.size() != 3 || neop != 0) begin
      errors++;
      $display("FAIL mid_abandon: got %0d beats %0d eop, required 3 and 0",
               obs_q.size(), neop);
    end
    req_val = '0;
    busy = 1'b0; busy_cd = 0; busy_left = 0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    obs_q.delete();
    fill(0, 2);
    model_pkt(0, 2);
    send_pkt(0, 2);
    wait_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_len: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[j]) begin
      if (j < obs_q.size()) begin
        checks++;
        if (pk(obs_q[j]) !== pk(exp_q[j])) begin
          errors++;
          $display("FAIL mid_beat%0d: got %h, required %h", j, pk(obs_q[j]), pk(exp_q[j]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_truncate();
    test_stray();
    test_no_busy();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
